// File: rtl/shared_mem_responder_pkg.sv
// Shared definitions for the remote memory responder: window tag, bus widths and the granted-access payload.
package shared_mem_responder_pkg;

  localparam int unsigned REMOTE_DATA_W = 16;
  localparam int unsigned REMOTE_ADDR_W = 16;

  localparam logic [1:0]               SHARED_WIN_TAG = 2'b01;
  localparam logic [REMOTE_DATA_W-1:0] OOW_READ_VAL   = 16'hFFFF;

  // Access selected by the arbiter this cycle.
  typedef struct packed {
    logic                     wr;
    logic                     rd;
    logic [REMOTE_ADDR_W-1:0] addr;
    logic [REMOTE_DATA_W-1:0] wdata;
  } access_t;

  function automatic logic in_window(input logic [REMOTE_ADDR_W-1:0] addr);
    return addr[REMOTE_ADDR_W-1 -: 2] == SHARED_WIN_TAG;
  endfunction

endpackage

// File: rtl/dpsram.sv
// Dual-port synchronous RAM: read-first, registered read data on both ports, no reset on the array.
module dpsram #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned WIDTH     = 16,
  parameter              INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     a_en,
  input  logic                     a_we,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_wdata,
  output logic [WIDTH-1:0]         a_rdata,
  input  logic                     b_en,
  input  logic                     b_we,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [WIDTH-1:0]         b_wdata,
  output logic [WIDTH-1:0]         b_rdata
);

  // The preload image is applied by the memory integration flow, not by this model.
  localparam int unsigned unused_init_bits = $bits(INIT_FILE);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
    end
    if (b_en) begin
      if (b_we) mem[b_addr] <= b_wdata;
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, then moves rr_ptr past the winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_next;
  logic             found;
  int unsigned      cand;

  // Search order starts at rr_ptr and wraps modulo N, so N need not be a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(rr_ptr) + k) % N;
      if (!found && req[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign ptr_next = IDX_W'((32'(grant_idx) + 32'd1) % N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rr_ptr <= '0;
    else if (advance && found) rr_ptr <= ptr_next;
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Responder for the per-core remote memory interface: one arbitrated access per cycle into a single-port
// shared memory, same-cycle ready, read data presented the cycle after the grant and held until the next read.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MEM_SIZE  = 4096,
  parameter              INIT_FILE = "shared.hex"
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [REMOTE_ADDR_W*NUM_CORES-1:0] remote_addr,
  input  logic [NUM_CORES-1:0]               remote_wren,
  input  logic [NUM_CORES-1:0]               remote_rden,
  output logic [NUM_CORES-1:0]               remote_ready,
  input  logic [REMOTE_DATA_W*NUM_CORES-1:0] remote_write_val,
  output logic [REMOTE_DATA_W*NUM_CORES-1:0] remote_read_val
);

  localparam int unsigned IDX_W  = $clog2(NUM_CORES);
  localparam int unsigned MEM_AW = $clog2(MEM_SIZE);

  logic [NUM_CORES-1:0]     req;
  logic [NUM_CORES-1:0]     grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     acc_vld;
  logic                     acc_win;
  logic                     mem_en;
  access_t                  acc;
  logic [REMOTE_DATA_W-1:0] mem_q;
  logic [REMOTE_DATA_W-1:0] fresh;
  logic [NUM_CORES-1:0]     rd_pend_l;
  logic                     oow_l;
  logic [REMOTE_DATA_W-1:0] hold_val [NUM_CORES];
  logic [REMOTE_DATA_W-1:0] unused_b_q;
  logic                     unused_acc;

  assign req = remote_wren | remote_rden;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .req       (req),
    .advance   (reset_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign acc_vld      = reset_n & (|grant);
  assign remote_ready = grant & {NUM_CORES{reset_n}};

  // Mux the granted core onto the single memory port; wren wins when both strobes are set.
  always_comb begin
    acc = '0;
    if (acc_vld) begin
      acc.wr    = remote_wren[grant_idx];
      acc.rd    = remote_rden[grant_idx];
      acc.addr  = remote_addr[32'(grant_idx)*REMOTE_ADDR_W +: REMOTE_ADDR_W];
      acc.wdata = remote_write_val[32'(grant_idx)*REMOTE_DATA_W +: REMOTE_DATA_W];
    end
  end

  assign acc_win    = in_window(acc.addr);
  assign mem_en     = acc_vld & acc_win;
  assign unused_acc = ^acc;

  dpsram #(
    .DEPTH     (MEM_SIZE),
    .WIDTH     (REMOTE_DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk     (clk),
    .a_en    (mem_en),
    .a_we    (acc.wr),
    .a_addr  (acc.addr[MEM_AW-1:0]),
    .a_wdata (acc.wdata),
    .a_rdata (mem_q),
    .b_en    (1'b0),
    .b_we    (1'b0),
    .b_addr  ('0),
    .b_wdata ('0),
    .b_rdata (unused_b_q)
  );

  // Only one read can be in flight per cycle, so a single out-of-window flag covers all cores.
  assign fresh = oow_l ? OOW_READ_VAL : mem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_l <= '0;
      oow_l     <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) hold_val[i] <= '0;
    end else begin
      rd_pend_l <= grant & {NUM_CORES{acc.rd & ~acc.wr}};
      oow_l     <= ~acc_win;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (rd_pend_l[i]) hold_val[i] <= fresh;
      end
    end
  end

  always_comb begin
    remote_read_val = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      remote_read_val[i*REMOTE_DATA_W +: REMOTE_DATA_W] = rd_pend_l[i] ? fresh : hold_val[i];
    end
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: per-core request queues feed a round-robin reference model
// that predicts grants and read data; a monitor compares ready and read_val every cycle.
module tb_shared_mem_responder;

  localparam int N        = 4;
  localparam int MEM_SIZE = 4096;

  logic          clk              = 1'b0;
  logic          reset_n          = 1'b1;
  logic [16*N-1:0] remote_addr      = '0;
  logic [16*N-1:0] remote_write_val = '0;
  logic [16*N-1:0] remote_read_val;
  logic [N-1:0]  remote_wren      = '0;
  logic [N-1:0]  remote_rden      = '0;
  logic [N-1:0]  remote_ready;

  shared_mem_responder #(
    .NUM_CORES (N),
    .MEM_SIZE  (MEM_SIZE),
    .INIT_FILE ("shared.hex")
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .remote_addr      (remote_addr),
    .remote_wren      (remote_wren),
    .remote_rden      (remote_rden),
    .remote_ready     (remote_ready),
    .remote_write_val (remote_write_val),
    .remote_read_val  (remote_read_val)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; bit rd; logic [15:0] addr; logic [15:0] data; } txn_t;
  typedef struct { int cyc; int core; } gexp_t;
  typedef struct { int cyc; int core; logic [15:0] val; } rexp_t;

  txn_t        txq [N][$];
  gexp_t       gq[$];
  rexp_t       rq[$];
  logic [15:0] model_mem [int];
  int          known_idx[$];
  logic [15:0] exp_hold [N];
  int          model_ptr = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int core, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s core %0d cycle %0d: got %h want %h", name, core, cyc, act, exp);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (txq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic issue(input int core, input bit wr, input bit rd, input logic [15:0] addr,
                       input logic [15:0] data);
    txn_t t;
    t.wr = wr; t.rd = rd; t.addr = addr; t.data = data;
    txq[core].push_back(t);
  endtask

  // One cycle: present each core's head request, then predict the grant from the round-robin rule.
  task automatic step();
    bit          req [N];
    int          g;
    int          c;
    int          idx;
    bit          win;
    txn_t        t;
    logic [15:0] v;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req[i] = txq[i].size() > 0;
      if (req[i]) begin
        t = txq[i][0];
        remote_wren[i] = t.wr;
        remote_rden[i] = t.rd;
        remote_addr[16*i +: 16]      = t.addr;
        remote_write_val[16*i +: 16] = t.data;
      end else begin
        remote_wren[i] = 1'b0;
        remote_rden[i] = 1'b0;
        remote_addr[16*i +: 16]      = 16'($urandom);
        remote_write_val[16*i +: 16] = 16'($urandom);
      end
    end
    if (reset_n) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (g < 0 && req[c]) g = c;
      end
      if (g >= 0) begin
        t = txq[g].pop_front();
        gq.push_back('{cyc, g});
        win = (t.addr >= 16'h4000) && (t.addr < 16'h8000);
        idx = int'(t.addr) % MEM_SIZE;
        if (t.wr) begin
          if (win) begin
            model_mem[idx] = t.data;
            known_idx.push_back(idx);
          end
        end else begin
          v = win ? model_mem[idx] : 16'hFFFF;
          rq.push_back('{cyc + 1, g, v});
        end
        model_ptr = (g + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    if (pending()) begin
      checks++;
      errors++;
      $display("FAIL drain: requests still queued after %0d cycles", budget);
      for (int i = 0; i < N; i++) txq[i].delete();
    end
  endtask

  task automatic apply_reset(input int ncyc);
    @(posedge clk); #1;
    reset_n = 1'b0;
    remote_wren = '0;
    remote_rden = '0;
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      exp_hold[i] = '0;
    end
    gq.delete();
    rq.delete();
    model_ptr = 0;
    repeat (ncyc) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [15:0] oow_addr();
    int sel;
    sel = $urandom_range(0, 2);
    return 16'((sel == 0 ? 0 : sel + 1) << 14) | 16'($urandom_range(0, 16383));
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   sel;
    int   idx;
    sel    = $urandom_range(0, 9);
    t.data = 16'($urandom);
    t.wr   = 1'b0;
    t.rd   = 1'b1;
    if (sel < 4) begin
      t.wr   = 1'b1;
      t.rd   = 1'($urandom_range(0, 1));
      t.addr = 16'h4000 | 16'($urandom_range(0, 16383));
    end else if (sel < 5) begin
      t.wr   = 1'b1;
      t.rd   = 1'b0;
      t.addr = oow_addr();
    end else if (sel < 9 && known_idx.size() > 0) begin
      idx    = known_idx[$urandom_range(0, known_idx.size() - 1)];
      t.addr = 16'(16'h4000 + idx + MEM_SIZE * $urandom_range(0, 16384 / MEM_SIZE - 1));
    end else begin
      t.addr = oow_addr();
    end
    return t;
  endfunction

  // Monitor: reset state, one-hot ready against predicted grants, read data and held values per core.
  initial begin : monitor
    logic [N-1:0] exp_ready;
    gexp_t        g;
    rexp_t        r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("reset_ready", -1, 16'(remote_ready), 16'h0);
        for (int i = 0; i < N; i++) chk("reset_read_val", i, remote_read_val[16*i +: 16], 16'h0);
      end else begin
        exp_ready = '0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          g = gq.pop_front();
          exp_ready[g.core] = 1'b1;
        end
        chk("ready", -1, 16'(remote_ready), 16'(exp_ready));
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          r = rq.pop_front();
          exp_hold[r.core] = r.val;
        end
        for (int i = 0; i < N; i++) chk("read_val", i, remote_read_val[16*i +: 16], exp_hold[i]);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    txn_t t;
    for (int i = 0; i < N; i++) exp_hold[i] = '0;
    apply_reset(3);

    // Write then read back through core 0.
    issue(0, 1'b1, 1'b0, 16'h4010, 16'hBEEF);
    issue(0, 1'b0, 1'b1, 16'h4010, 16'h0000);
    run_until_idle(20);
    idle(3);

    // Write by core 0 immediately followed by a read of the same word by core 1.
    issue(0, 1'b1, 1'b0, 16'h4020, 16'h1234);
    step();
    issue(1, 1'b0, 1'b1, 16'h4020, 16'h0000);
    run_until_idle(20);
    idle(2);

    // Out-of-window read and write from core 1; the aliased word must be untouched.
    issue(1, 1'b1, 1'b0, 16'h4123, 16'h0A0A);
    issue(1, 1'b0, 1'b1, 16'h8000, 16'h0000);
    issue(1, 1'b1, 1'b0, 16'hC123, 16'h5555);
    issue(1, 1'b0, 1'b1, 16'h4123, 16'h0000);
    run_until_idle(20);
    idle(2);

    // All cores read in the same cycle straight out of reset; memory survives reset.
    apply_reset(2);
    issue(0, 1'b0, 1'b1, 16'h4010, 16'h0000);
    issue(1, 1'b0, 1'b1, 16'h4020, 16'h0000);
    issue(2, 1'b0, 1'b1, 16'h4123, 16'h0000);
    issue(3, 1'b0, 1'b1, 16'h8000, 16'h0000);
    run_until_idle(20);
    idle(2);

    // Reset lands in the cycle core 3's read data is due; pointer restarts at core 0.
    issue(3, 1'b0, 1'b1, 16'h4020, 16'h0000);
    run_until_idle(20);
    apply_reset(2);
    for (int i = 0; i < N; i++) issue(i, 1'b0, 1'b1, 16'h4010, 16'h0000);
    run_until_idle(20);
    idle(2);

    // Core 0 streams requests while core 2 joins.
    for (int k = 0; k < 8; k++) issue(0, 1'(k % 2), 1'(1 - k % 2), 16'h4010 + 16'(k % 2) * 16'h30, 16'(16'hA000 + k));
    step();
    step();
    issue(2, 1'b0, 1'b1, 16'h4010, 16'h0000);
    run_until_idle(40);
    idle(2);

    // Randomised traffic from all cores.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() == 0 && $urandom_range(0, 2) != 0) begin
          t = rand_txn();
          issue(i, t.wr, t.rd, t.addr, t.data);
        end
      end
      step();
    end
    run_until_idle(100);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
